// File: rtl/dbg_bus_pkg.sv
// Shared types and constants for the debug bus switch and its trigger latch.
package dbg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PCTRL_WR = 2'd0,
        PCTRL_RD = 2'd1,
        LMON_WR  = 2'd2,
        LMON_RD  = 2'd3
    } stb_e;

    localparam int unsigned ERR_RDATA = 0;

    function automatic int unsigned bcast_sel(input int unsigned sel_w);
        return (32'd1 << sel_w) - 32'd1;
    endfunction

endpackage

// File: rtl/dbg_bus_switch_if.sv
// Upstream DAP request/response and downstream per-channel bus of the debug switch.
interface dbg_bus_switch_if #(
    parameter int NCH    = 4,
    parameter int SEL_W  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic [SEL_W-1:0]      iSel;
    logic [ADDR_W-1:0]     iAddr;
    logic [DATA_W-1:0]     iData;
    logic [LEN_W-1:0]      iLen;
    logic [ADDR_W-1:0]     iUpAddr;
    logic                  iPCtrlWen, iPCtrlRen, iLMonWen, iLMonRen;
    logic [DATA_W-1:0]     oPCtrlRD, oLMonRD;
    logic                  oRdy, oErr;

    logic [NCH-1:0]        oSel;
    logic [ADDR_W-1:0]     oAddr;
    logic [DATA_W-1:0]     oData;
    logic [LEN_W-1:0]      oLen;
    logic [ADDR_W-1:0]     oUpAddr;
    logic [NCH-1:0]        oPCtrlWen, oPCtrlRen, oLMonWen, oLMonRen;
    logic [NCH*DATA_W-1:0] iPCtrlRD, iLMonRD;
    logic [NCH-1:0]        iRdy;

    modport slave (
        input  iSel, iAddr, iData, iLen, iUpAddr,
        input  iPCtrlWen, iPCtrlRen, iLMonWen, iLMonRen,
        output oPCtrlRD, oLMonRD, oRdy, oErr,
        output oSel, oAddr, oData, oLen, oUpAddr,
        output oPCtrlWen, oPCtrlRen, oLMonWen, oLMonRen,
        input  iPCtrlRD, iLMonRD, iRdy
    );

    modport master (
        output iSel, iAddr, iData, iLen, iUpAddr,
        output iPCtrlWen, iPCtrlRen, iLMonWen, iLMonRen,
        input  oPCtrlRD, oLMonRD, oRdy, oErr,
        input  oSel, oAddr, oData, oLen, oUpAddr,
        input  oPCtrlWen, oPCtrlRen, oLMonWen, oLMonRen,
        output iPCtrlRD, iLMonRD, iRdy
    );
endinterface

// File: rtl/dbg_trig_latch.sv
// Sticky per-channel trigger latch: masked set, software clear (clear wins), any-flag.
module dbg_trig_latch #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] trig_i,
    input  logic [NCH-1:0] mask_i,
    input  logic [NCH-1:0] clr_i,
    output logic [NCH-1:0] sticky_o,
    output logic           any_o
);
    logic [NCH-1:0] sticky_q, sticky_d;

    assign sticky_d = (sticky_q | (trig_i & mask_i)) & ~clr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_o = sticky_q;
    assign any_o    = |sticky_q;
endmodule

// File: rtl/dbg_bus_switch.sv
// Routes one DAP debug transaction to one of NCH channels (or broadcasts a write) and
// holds it until the targets are ready or a timeout expires.
//   state | meaning
//   IDLE  | wait for a request strobe, decode target channels
//   ISSUE | one-cycle strobe onto the target channels
//   WAIT  | accumulate target Rdy, count towards timeout
//   RESP  | one-cycle oRdy (and oErr / read data)
module dbg_bus_switch
    import dbg_bus_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int SEL_W  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int TMO_W  = 10
) (
    input  logic           iSoCClk,
    input  logic           iSoCRst,
    dbg_bus_switch_if.slave bus,
    input  logic [NCH-1:0] iTrigger_lat,
    input  logic [NCH-1:0] iTrigMask,
    input  logic [NCH-1:0] iTrigClr,
    output logic [NCH-1:0] oTrigger_lat,
    output logic           oTrigAny
);
    localparam logic [SEL_W-1:0]  SEL_BCAST = SEL_W'(bcast_sel(SEL_W));
    localparam logic [TMO_W-1:0]  TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [NCH-1:0]    ALL_CH    = '1;
    localparam logic [DATA_W-1:0] ERR_DATA  = DATA_W'(ERR_RDATA);

    state_e              state_q;
    logic [3:0]          req_stb;
    logic                multi_d, rd_d, err_d;
    logic [NCH-1:0]      chan_d, done_d;
    logic [SEL_W-1:0]    sel_q;
    logic [3:0]          stb_q;
    logic [NCH-1:0]      tgt_q, done_q, osel_q;
    logic [TMO_W-1:0]    cnt_q;
    logic [3:0][NCH-1:0] ostb_q;
    logic [ADDR_W-1:0]   addr_q, upaddr_q;
    logic [DATA_W-1:0]   data_q, prd_q, lrd_q, slice_p, slice_l;
    logic [LEN_W-1:0]    len_q;
    logic                rdy_q, err_q;

    // bit index follows stb_e
    assign req_stb = {bus.iLMonRen, bus.iLMonWen, bus.iPCtrlRen, bus.iPCtrlWen};

    always_comb begin
        multi_d = (req_stb & (req_stb - 4'd1)) != 4'd0;
        rd_d    = req_stb[PCTRL_RD] | req_stb[LMON_RD];
        chan_d  = '0;
        err_d   = multi_d;
        if (bus.iSel == SEL_BCAST) begin
            chan_d = ALL_CH;
            err_d  = multi_d | rd_d;
        end else if (32'(bus.iSel) < NCH) begin
            chan_d = NCH'(1) << bus.iSel;
        end else begin
            err_d = 1'b1;
        end
    end

    // Rdy seen earlier in WAIT stays counted, so broadcast slaves may answer unaligned.
    assign done_d  = done_q | (bus.iRdy & tgt_q);
    assign slice_p = bus.iPCtrlRD[32'(sel_q)*DATA_W +: DATA_W];
    assign slice_l = bus.iLMonRD[32'(sel_q)*DATA_W +: DATA_W];

    always_ff @(posedge iSoCClk or posedge iSoCRst) begin
        if (iSoCRst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            stb_q    <= '0;
            tgt_q    <= '0;
            done_q   <= '0;
            cnt_q    <= '0;
            osel_q   <= '0;
            ostb_q   <= '0;
            addr_q   <= '0;
            upaddr_q <= '0;
            data_q   <= '0;
            len_q    <= '0;
            prd_q    <= '0;
            lrd_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            prd_q  <= ERR_DATA;
            lrd_q  <= ERR_DATA;
            ostb_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_stb != 4'd0) begin
                        sel_q    <= bus.iSel;
                        stb_q    <= req_stb;
                        tgt_q    <= chan_d;
                        done_q   <= '0;
                        cnt_q    <= '0;
                        addr_q   <= bus.iAddr;
                        upaddr_q <= bus.iUpAddr;
                        data_q   <= bus.iData;
                        len_q    <= bus.iLen;
                        if (err_d) begin
                            state_q <= RESP;
                            rdy_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            osel_q  <= chan_d;
                            for (int k = 0; k < 4; k++) begin
                                ostb_q[k] <= req_stb[k] ? chan_d : '0;
                            end
                        end
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    done_q <= done_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (done_d == tgt_q) begin
                        state_q <= RESP;
                        rdy_q   <= 1'b1;
                        osel_q  <= '0;
                        if (stb_q[PCTRL_RD]) prd_q <= slice_p;
                        if (stb_q[LMON_RD])  lrd_q <= slice_l;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q <= RESP;
                        rdy_q   <= 1'b1;
                        err_q   <= 1'b1;
                        osel_q  <= '0;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oRdy      = rdy_q;
    assign bus.oErr      = err_q;
    assign bus.oPCtrlRD  = prd_q;
    assign bus.oLMonRD   = lrd_q;
    assign bus.oSel      = osel_q;
    assign bus.oAddr     = addr_q;
    assign bus.oData     = data_q;
    assign bus.oLen      = len_q;
    assign bus.oUpAddr   = upaddr_q;
    assign bus.oPCtrlWen = ostb_q[PCTRL_WR];
    assign bus.oPCtrlRen = ostb_q[PCTRL_RD];
    assign bus.oLMonWen  = ostb_q[LMON_WR];
    assign bus.oLMonRen  = ostb_q[LMON_RD];

    dbg_trig_latch #(.NCH(NCH)) u_trig (
        .clk      (iSoCClk),
        .rst      (iSoCRst),
        .trig_i   (iTrigger_lat),
        .mask_i   (iTrigMask),
        .clr_i    (iTrigClr),
        .sticky_o (oTrigger_lat),
        .any_o    (oTrigAny)
    );
endmodule
